// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP test-pattern source.
//   rgb565_t        : packed RGB565 pixel (r[4:0], g[5:0], b[4:0])
//   dvp_tx_state_e  : frame FSM states
//   BAR_COLOURS     : colour-bar palette, left to right
//   cnt_width()     : bits needed to hold the values 0..n-1 (minimum 1)
package dvp_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    HBLANK,
    VFRONT
  } dvp_tx_state_e;

  localparam rgb565_t BAR_COLOURS [8] = '{
    rgb565_t'(16'hFFFF), rgb565_t'(16'hFFE0), rgb565_t'(16'h07FF), rgb565_t'(16'h07E0),
    rgb565_t'(16'hF81F), rgb565_t'(16'hF800), rgb565_t'(16'h001F), rgb565_t'(16'h0000)
  };

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dvp_pattern_tx_if.sv
// DVP byte bus: VSYNC, HREF/DE and 8-bit data.
//   master : source side (drives the bus)
//   slave  : sink side (capture path)
interface dvp_pattern_tx_if;
  logic       dvp_vsync;
  logic       dvp_de;
  logic [7:0] dvp_data;

  modport master (output dvp_vsync, output dvp_de, output dvp_data);
  modport slave  (input  dvp_vsync, input  dvp_de, input  dvp_data);
endinterface

// File: rtl/dvp_tx_pixel_gen.sv
// Pixel value generator for the DVP test-pattern source.
// The value is produced for the *next* byte position (x/y are the upcoming
// pixel coordinates), so the top can register the selected byte.
// Build option DVP_TX_BARS_EN:
//   defined   : 8 vertical colour bars, H_ACTIVE/8 pixels each; the bar index
//               follows restart/step pulses through a sub-counter
//   undefined : ramp, pixel = {x[4:0], y[5:0], frame_cnt[4:0]}
// Ports:
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   restart    : upcoming pixel is x=0 of a line
//   step       : upcoming byte starts a new pixel (x advances by one)
//   x, y       : upcoming pixel coordinates
//   frame_cnt  : current frame number
//   pixel      : RGB565 value for the upcoming pixel
module dvp_tx_pixel_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic          step,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [7:0]    frame_cnt,
  output rgb565_t       pixel
);

`ifdef DVP_TX_BARS_EN
  localparam int BAR_W = H_ACTIVE >> 3;
  localparam int BW    = cnt_width(BAR_W);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [2:0]    bar_q, bar_d;
  logic [BW-1:0] px_q, px_d;
  logic          unused_ok;

  // Sub-counter: px counts pixels inside the current bar, bar moves on
  // when px wraps. The combinational next value drives the output so the
  // colour lines up with x.
  always_comb begin
    bar_d = bar_q;
    px_d  = px_q;
    if (restart) begin
      bar_d = '0;
      px_d  = '0;
    end else if (step) begin
      if (px_q == BAR_LAST) begin
        bar_d = bar_q + 3'd1;
        px_d  = '0;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_q <= '0;
      px_q  <= '0;
    end else begin
      bar_q <= bar_d;
      px_q  <= px_d;
    end
  end

  assign pixel     = BAR_COLOURS[bar_d];
  assign unused_ok = ^{x, y, frame_cnt};
`else
  localparam int unused_bar_w = H_ACTIVE >> 3;

  logic [15:0] x_ext, y_ext;
  logic        unused_ok;

  // Zero-extend first so narrow coordinates still fill their slice.
  assign x_ext     = 16'(x);
  assign y_ext     = 16'(y);
  assign pixel     = rgb565_t'({x_ext[4:0], y_ext[5:0], frame_cnt[4:0]});
  assign unused_ok = ^{clk, rst_n, restart, step, x_ext[15:5], y_ext[15:6], frame_cnt[7:5]};
`endif

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP test-pattern source: OV-style VSYNC / HREF(DE) / 8-bit data carrying
// RGB565 frames, two bytes per pixel, high byte first. Frames start only
// while en is high; a started frame always runs to completion.
// Optional colour-bar pattern: define DVP_TX_BARS_EN (handled in dvp_tx_pixel_gen).
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   en          : level, frame generation allowed (sampled at frame boundaries)
//   dvp         : master side of the DVP bus (vsync, de, data)
//   frame_start : one-cycle pulse on the first VSYNC-high cycle
//   busy        : high whenever a frame is in progress
//   frame_cnt   : completed-frame count, wraps 255 -> 0
module dvp_pattern_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  dvp_pattern_tx_if.master    dvp,
  output logic                frame_start,
  output logic                busy,
  output logic [7:0]          frame_cnt
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int ACT_LEN  = 2 * H_ACTIVE;
  localparam int VS_LEN   = VSYNC_LINES * LINE_LEN;
  localparam int VB_LEN   = V_BACK * LINE_LEN;
  localparam int VF_LEN   = V_FRONT * LINE_LEN;
  localparam int MAX_A    = (VS_LEN > VB_LEN) ? VS_LEN : VB_LEN;
  localparam int MAX_LEN  = (MAX_A > VF_LEN) ? MAX_A : VF_LEN;
  localparam int CW       = cnt_width(MAX_LEN);
  localparam int XW       = cnt_width(H_ACTIVE);
  localparam int LW       = cnt_width(V_ACTIVE);

  // Last-cycle values per period; zero-length periods are never entered.
  localparam logic [CW-1:0] VS_LAST   = CW'(VS_LEN - 1);
  localparam logic [CW-1:0] VB_LAST   = (V_BACK > 0)  ? CW'(VB_LEN - 1) : '0;
  localparam logic [CW-1:0] VF_LAST   = (V_FRONT > 0) ? CW'(VF_LEN - 1) : '0;
  localparam logic [CW-1:0] ACT_LAST  = CW'(ACT_LEN - 1);
  localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

  dvp_tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] line_q, line_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          frame_done;

  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [7:0]    data_q, data_d;
  logic          fs_q, fs_d;
  logic          busy_q, busy_d;

  logic          pix_restart, pix_step;
  rgb565_t       pixel;
  logic [15:0]   pix_bits;

  // Next-state: cnt counts cycles inside the current period.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    line_d      = line_q;
    frame_cnt_d = frame_cnt_q;
    frame_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = VSYNC;
      end
      VSYNC: if (cnt_q == VS_LAST) begin
        cnt_d   = '0;
        line_d  = '0;
        state_d = (V_BACK > 0) ? VBACK : ACTIVE;
      end
      VBACK: if (cnt_q == VB_LAST) begin
        cnt_d   = '0;
        line_d  = '0;
        state_d = ACTIVE;
      end
      ACTIVE: if (cnt_q == ACT_LAST) begin
        cnt_d   = '0;
        state_d = HBLANK;
      end
      HBLANK: if (cnt_q == HB_LAST) begin
        cnt_d = '0;
        if (line_q == LINE_LAST) begin
          if (V_FRONT > 0) state_d = VFRONT;
          else             frame_done = 1'b1;
        end else begin
          line_d  = line_q + 1'b1;
          state_d = ACTIVE;
        end
      end
      VFRONT: if (cnt_q == VF_LAST) frame_done = 1'b1;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // en is only looked at here, so deasserting it mid-frame has no effect.
    if (frame_done) begin
      cnt_d       = '0;
      frame_cnt_d = frame_cnt_q + 8'd1;
      state_d     = en ? VSYNC : IDLE;
    end
  end

  // Outputs are decoded from the next state so the registered outputs line
  // up with state_q; data is built from the upcoming byte position.
  always_comb begin
    vsync_d = (state_d == VSYNC);
    de_d    = (state_d == ACTIVE);
    fs_d    = (state_d == VSYNC) && (state_q != VSYNC);
    busy_d  = (state_d != IDLE);
    data_d  = de_d ? (cnt_d[0] ? pix_bits[7:0] : pix_bits[15:8]) : 8'h00;
  end

  assign pix_restart = de_d && (cnt_d == '0);
  assign pix_step    = de_d && !cnt_d[0] && !pix_restart;
  assign pix_bits    = pixel;

  dvp_tx_pixel_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW),
    .YW       (LW)
  ) u_pixel_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (pix_restart),
    .step      (pix_step),
    .x         (cnt_d[XW:1]),
    .y         (line_d),
    .frame_cnt (frame_cnt_q),
    .pixel     (pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      frame_cnt_q <= '0;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      data_q      <= 8'h00;
      fs_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      data_q      <= data_d;
      fs_q        <= fs_d;
      busy_q      <= busy_d;
    end
  end

  assign dvp.dvp_vsync = vsync_q;
  assign dvp.dvp_de    = de_q;
  assign dvp.dvp_data  = data_q;
  assign frame_start   = fs_q;
  assign busy          = busy_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: doc/dvp_pattern_tx.md
Name: dvp_pattern_tx

Overview:
- DVP source: drives OV-style VSYNC/HREF(DE)/8-bit data with RGB565 test frames, two bytes per pixel, high byte first.
- Sits on the `dvp_pixel_clk` side. Used as the bring-up and bench stimulus for the DVP capture path in place of the camera sensor.
- Free-running frame generator. Frames start only while enabled, and a started frame always completes.

Parameters:
- H_ACTIVE, 640, pixels per active line (even, ≥8, divisible by 8)
- V_ACTIVE, 480, active lines per frame
- H_BLANK, 144, DE-low cycles after each line's active bytes
- VSYNC_LINES, 3, line periods with VSYNC high
- V_BACK, 17, line periods between VSYNC fall and first active line
- V_FRONT, 10, line periods after last active line

Ports:
- clk  input  1  pixel clock; all outputs change on its rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  level; frame generation allowed
- dvp_vsync  output  1  frame sync, active high
- dvp_de  output  1  byte valid (HREF)
- dvp_data  output  8  pixel byte
- frame_start  output  1  one-cycle pulse coincident with first VSYNC-high cycle
- busy  output  1  high while any frame is in progress
- frame_cnt  output  8  completed-frame count, wraps 255→0

Behaviour:
- Timing constants:
  - LINE_LEN = 2*H_ACTIVE + H_BLANK cycles.
  - Every period, including vblank, is counted in LINE_LEN units.
  - Frame length = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * LINE_LEN cycles.
- Reset: all outputs 0, state IDLE. Reset mid-frame aborts immediately; outputs go to 0 asynchronously.
- FSM states and transitions:
  - IDLE: en=1 sampled → VSYNC. dvp_vsync and frame_start are 1 on the next cycle.
  - VSYNC: VSYNC_LINES*LINE_LEN cycles with dvp_vsync=1, de=0 → VBACK.
  - VBACK: V_BACK*LINE_LEN cycles, all low → ACTIVE.
  - ACTIVE: 2*H_ACTIVE cycles with de=1 → HBLANK.
  - HBLANK: H_BLANK cycles, de=0. Then → ACTIVE if more lines remain, else → VFRONT.
  - VFRONT: V_FRONT*LINE_LEN cycles. Then frame_cnt increments; → VSYNC if en=1, else → IDLE.
- Zero-length vertical periods: V_BACK=0 or V_FRONT=0 skips that state; no idle cycle is inserted.
- Disable behaviour:
  - en is ignored mid-frame; deasserting it ends generation only at frame end.
  - busy=1 in every state except IDLE.
- dvp_data outside ACTIVE: 8'h00.
- Byte order: in ACTIVE, even byte cycle = pixel[15:8], odd = pixel[7:0].
  - Pixel x = byte_cnt>>1 (0..H_ACTIVE-1); y = active line index (0..V_ACTIVE-1).
- Output timing:
  - All outputs are registered.
  - dvp_de and dvp_data are aligned: the pixel value is computed one cycle ahead of the byte shown.
- Counter width: $clog2 of the largest count + 1 is sufficient. No division in RTL.

Optional Feature:
- Macro DVP_TX_BARS_EN.
- Defined: 8 vertical colour bars, each H_ACTIVE/8 pixels wide.
  - Bar index is tracked by a sub-counter, not a divider.
  - Colours, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Undefined: ramp pattern, pixel = {x[4:0], y[5:0], frame_cnt[4:0]}.
  - x and y are zero-extended when narrower than the slice.

Decomposition:
- Package dvp_pkg holds:
  - typedef rgb565_t (packed struct r[4:0], g[5:0], b[4:0])
  - enum dvp_tx_state_e {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT}
  - the 8-entry bar colour constant array
- One sub-module, dvp_tx_pixel_gen: combinational/registered pixel value from x, y, frame_cnt. The macro lives only there.

Test Plan:
All scenarios use H_ACTIVE=8, H_BLANK=2, V_ACTIVE=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1. This gives LINE_LEN=18 and frame=108 cycles.
- Reset release, en=0 for 50 cycles → all outputs 0, busy=0.
- en=1 held → frame_start pulse:
  - period exactly 108 cycles
  - dvp_vsync high 18 cycles per frame
  - dvp_de high for 3 runs of 16 cycles, separated by 2-cycle gaps
  - first DE rise 36 cycles after VSYNC rise
- Ramp build, frame 0, line 1, pixel 3 → bytes 8'h18, 8'h20 (pixel 16'h1820).
  - Bars build, line 0 → byte pairs FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00.
- en pulsed one cycle, then 0 → exactly one full frame, frame_cnt 0→1, busy falls the cycle after VFRONT ends, no second frame_start.
- rst_n asserted mid-ACTIVE → dvp_de/dvp_data/dvp_vsync/busy go 0 without a clock edge.
  - After release with en=1: clean frame, frame_cnt=0.
- 256 back-to-back frames → frame_cnt wraps to 0; no idle gap between consecutive frames.
